// File: rtl/write_checker_pkg.sv
// write_checker_pkg: shared state encoding and fail codes for the write checker.
// Rev 1.0
`default_nettype none

package write_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_ORDER    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/write_match_table.sv
// write_match_table: expected-write storage with per-entry match vectors and
// one-hot lowest-unhit pointer / lowest-unhit address candidate.
// Rev 1.0
`default_nettype none

module write_match_table
    import write_checker_pkg::*;
#(
    parameter int N     = 32,
    parameter int A     = 32,
    parameter int DEPTH = 4,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [IW-1:0]    wr_idx_i,
    input  logic             wr_valid_i,
    input  logic [A-1:0]     wr_addr_i,
    input  logic [N-1:0]     wr_data_i,
    input  logic [A-1:0]     dataadr_i,
    input  logic [N-1:0]     writedata_i,
    input  logic [DEPTH-1:0] hit_mask_i,
    output logic [DEPTH-1:0] valid_o,
    output logic [DEPTH-1:0] addr_match_o,
    output logic [DEPTH-1:0] data_match_o,
    output logic [DEPTH-1:0] ptr_oh_o,
    output logic [DEPTH-1:0] cand_oh_o
);

    logic [DEPTH-1:0] valid_q;
    logic [A-1:0]     addr_q [DEPTH];
    logic [N-1:0]     data_q [DEPTH];

    logic [DEPTH-1:0] w_unhit;
    logic [DEPTH-1:0] w_cand_pool;

    // Indices outside 0..DEPTH-1 match no entry and are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx_i == IW'(i)) begin
                    valid_q[i] <= wr_valid_i;
                    addr_q[i]  <= wr_addr_i;
                    data_q[i]  <= wr_data_i;
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign addr_match_o[i] = valid_q[i] && (addr_q[i] == dataadr_i);
        assign data_match_o[i] = (data_q[i] == writedata_i);
    end

    assign valid_o     = valid_q;
    assign w_unhit     = valid_q & ~hit_mask_i;
    assign w_cand_pool = addr_match_o & ~hit_mask_i;

    // x & -x isolates the lowest set bit.
    assign ptr_oh_o  = w_unhit & (~w_unhit + DEPTH'(1));
    assign cand_oh_o = w_cand_pool & (~w_cand_pool + DEPTH'(1));

endmodule

`default_nettype wire

// File: rtl/write_checker.sv
// write_checker: snoops the data-memory write port against a table of expected
// writes and raises sticky pass/fail flags with a cycle watchdog.  Rev 1.0
`default_nettype none

module write_checker
    import write_checker_pkg::*;
#(
    parameter int   N       = 32,
    parameter int   A       = 32,
    parameter int   DEPTH   = 4,
    parameter int   TIMEOUT = 1000,
    parameter int   CW      = $clog2(TIMEOUT + 1),
    localparam int  IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [A-1:0]     dataadr,
    input  logic [N-1:0]     writedata,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic             cfg_valid,
    input  logic [A-1:0]     cfg_addr,
    input  logic [N-1:0]     cfg_data,
    input  logic             ordered,
    input  logic             start,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [DEPTH-1:0] hit_mask,
    output logic [CW-1:0]    cycles
);

    state_e           state_q;
    logic             ordered_q;
    logic             busy_q;
    logic             pass_q;
    logic             fail_q;
    logic [1:0]       fail_code_q;
    logic [DEPTH-1:0] hit_mask_q;
    logic [CW-1:0]    cycles_q;

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_addr_match;
    logic [DEPTH-1:0] w_data_match;
    logic [DEPTH-1:0] w_ptr_oh;
    logic [DEPTH-1:0] w_cand_oh;
    logic [DEPTH-1:0] w_new_hit;
    logic             w_mismatch;
    logic             w_order_err;
    logic             w_complete;
    logic             w_timeout;
    logic [CW-1:0]    w_cycles_inc;

    write_match_table #(
        .N     (N),
        .A     (A),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_table (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (cfg_we && (state_q == IDLE)),
        .wr_idx_i     (cfg_idx),
        .wr_valid_i   (cfg_valid),
        .wr_addr_i    (cfg_addr),
        .wr_data_i    (cfg_data),
        .dataadr_i    (dataadr),
        .writedata_i  (writedata),
        .hit_mask_i   (hit_mask_q),
        .valid_o      (w_valid),
        .addr_match_o (w_addr_match),
        .data_match_o (w_data_match),
        .ptr_oh_o     (w_ptr_oh),
        .cand_oh_o    (w_cand_oh)
    );

    always_comb begin
        w_new_hit   = '0;
        w_mismatch  = 1'b0;
        w_order_err = 1'b0;
        if (memwrite) begin
            if (!ordered_q) begin
                if (|w_cand_oh) begin
                    if (|(w_cand_oh & w_data_match)) w_new_hit = w_cand_oh;
                    else                             w_mismatch = 1'b1;
                end else if (|(w_addr_match & hit_mask_q) &&
                             !(|(w_addr_match & hit_mask_q & w_data_match))) begin
                    w_mismatch = 1'b1;
                end
            end else if (|(w_ptr_oh & w_addr_match)) begin
                if (|(w_ptr_oh & w_data_match)) w_new_hit = w_ptr_oh;
                else                            w_mismatch = 1'b1;
            end else if (|(w_addr_match & ~hit_mask_q)) begin
                w_order_err = 1'b1;
            end
        end
    end

    assign w_complete   = (((hit_mask_q | w_new_hit) & w_valid) == w_valid);
    assign w_timeout    = (cycles_q == CW'(TIMEOUT - 1));
    assign w_cycles_inc = (cycles_q == {CW{1'b1}}) ? cycles_q : cycles_q + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ordered_q   <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= FC_NONE;
            hit_mask_q  <= '0;
            cycles_q    <= '0;
        end else begin
            case (state_q)
                ARMED: begin
                    cycles_q   <= w_cycles_inc;
                    hit_mask_q <= hit_mask_q | w_new_hit;
                    // Completion outranks an error or watchdog expiry on the same edge.
                    if (w_complete) begin
                        state_q <= PASS;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b1;
                    end else if (w_mismatch || w_order_err || w_timeout) begin
                        state_q     <= FAIL;
                        busy_q      <= 1'b0;
                        fail_q      <= 1'b1;
                        fail_code_q <= w_mismatch  ? FC_MISMATCH :
                                       w_order_err ? FC_ORDER    : FC_TIMEOUT;
                    end
                end
                default: begin
                    if (start) begin
                        ordered_q   <= ordered;
                        hit_mask_q  <= '0;
                        cycles_q    <= '0;
                        fail_q      <= 1'b0;
                        fail_code_q <= FC_NONE;
                        if (|w_valid) begin
                            state_q <= ARMED;
                            busy_q  <= 1'b1;
                            pass_q  <= 1'b0;
                        end else begin
                            state_q <= PASS;
                            busy_q  <= 1'b0;
                            pass_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign hit_mask  = hit_mask_q;
    assign cycles    = cycles_q;

endmodule

`default_nettype wire
